sys_bus: RTL
============

Name: sys_bus

Overview:
Handshaked data-side interconnect between the CPU load/store port and N_SLV memory-mapped slaves (memory, uart, timer, ...).
- Decodes each request against parametrised base/mask regions.
- Drives exactly one slave and waits for its ready, so slaves may insert wait states.
- Returns a one-cycle response. Decode misses and, optionally, slave hangs become error responses.
- Successor to the fixed three-slave, zero-wait combinational bus.

Parameters:
XLEN, 64, data/address width
N_SLV, 3, number of slaves
SLV_BASE, {64'hA000_0048, 64'hA000_03F8, 64'h8000_0000}, packed N_SLV*XLEN; slot i = bits [i*XLEN +: XLEN]
SLV_MASK, {~64'h7, ~64'h7, 64'hFFFF_FFFF_F800_0000}, packed N_SLV*XLEN; hit_i = ((addr & MASK_i) == BASE_i)
TMO_CYC, 255, ACCESS-cycle limit before timeout (BUS_TIMEOUT_EN only)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
m_valid  in  1  master request valid
m_ready  out  1  bus accepts a request this cycle
m_wr  in  1  1 = write, 0 = read
m_strb  in  XLEN/8  byte strobes
m_addr  in  XLEN  byte address
m_wdata  in  XLEN  write data
m_rvalid  out  1  response valid, one-cycle pulse
m_rdata  out  XLEN  read data; 0 for writes and errors
m_error  out  1  response is an error; qualified by m_rvalid
s_cen  out  N_SLV  one-hot slave select
s_wr  out  1  shared write flag
s_strb  out  XLEN/8  shared strobes
s_addr  out  XLEN  shared full address
s_wdata  out  XLEN  shared write data
s_ready  in  N_SLV  per-slave completion
s_rdata  in  N_SLV*XLEN  per-slave read data, packed
s_error  in  N_SLV  per-slave error; sampled with s_ready

Behaviour:
- Reset values: state = IDLE; s_cen = 0; m_rvalid = 0; m_error = 0; m_rdata = 0; latched wr/strb/addr/wdata = 0. m_ready = 1 while in IDLE, including during reset.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - m_ready = 1.
  - On m_valid: latch wr, strb, addr, wdata and compute sel = lowest-index hit (overlapping regions: lowest index wins).
  - Hit -> ACCESS. No hit -> RESP with error = 1, rdata = 0.
- ACCESS:
  - m_ready = 0; s_cen[sel] = 1; s_* show the latched fields, held stable until completion.
  - On s_ready[sel]: capture s_rdata[sel] (forced to 0 for writes) and s_error[sel], drop s_cen, go to RESP.
  - s_ready of unselected slaves is ignored.
- RESP:
  - m_ready = 0; m_rvalid = 1 for exactly one cycle with the captured m_rdata/m_error; then IDLE.
  - Outside RESP, m_rvalid = 0 and m_rdata/m_error = 0.
- Latency, request accepted at edge 0 with zero-wait slave: s_cen high in cycle 1, m_rvalid in cycle 2, next accept in cycle 3. Each slave wait cycle adds 1.
- Decode error: m_rvalid one cycle after acceptance; no s_cen ever asserts.
- s_ready asserted in IDLE or RESP is ignored.
- m_valid is ignored outside IDLE; the master holds the request until m_ready && m_valid.
- Reset mid-ACCESS: s_cen drops asynchronously; no response is generated for the abandoned request.
- No alignment checking in this block; strobes pass through unchanged.

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - An 8..16-bit counter (width $clog2(TMO_CYC+1)) clears on entry to ACCESS and increments each ACCESS cycle without s_ready[sel].
  - When the count equals TMO_CYC: drop s_cen, go to RESP with error = 1, rdata = 0.
  - s_ready arriving in the same cycle as the timeout wins; it is a normal completion.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Read 0x8000_0010, slave 0 ready with rdata 0x1122_3344_5566_7788 in first ACCESS cycle -> s_cen = 3'b001 for 1 cycle; m_rvalid 2 cycles after accept; m_rdata = 0x1122_3344_5566_7788; m_error = 0.
- Write 0xA000_03F8, wdata 0x41, strb 0x01, slave 1 ready after 3 wait cycles -> s_cen = 3'b010 held 4 cycles with s_wdata/s_strb stable; m_rvalid with m_rdata = 0, m_error = 0.
- Read 0x0000_1000 (no region) -> no s_cen; m_rvalid next cycle, m_error = 1, m_rdata = 0.
- Slave 2 (0xA000_0048) returns s_error = 1 with s_ready -> m_error = 1; a back-to-back request at the following IDLE accepts normally.
- BUS_TIMEOUT_EN, TMO_CYC = 4, slave 0 never ready -> s_cen high 4 cycles, then m_rvalid with m_error = 1. Without the macro -> s_cen stays high, no m_rvalid after 300 cycles.
- rst asserted in the 2nd ACCESS cycle -> s_cen = 0 immediately, m_rvalid never pulses; after release a new read completes normally.

Source files
------------

// File: rtl/sys_bus.sv
// Handshaked CPU data-side interconnect: base/mask decode, one-hot slave select, wait-state tolerant.
// Optional macro BUS_TIMEOUT_EN turns a slave that never answers into an error response after TMO_CYC cycles.
module sys_bus #(
    parameter int                       XLEN     = 64,
    parameter int                       N_SLV    = 3,
    parameter logic [N_SLV*XLEN-1:0]    SLV_BASE = {64'hA000_0048, 64'hA000_03F8, 64'h8000_0000},
    parameter logic [N_SLV*XLEN-1:0]    SLV_MASK = {~64'h7, ~64'h7, 64'hFFFF_FFFF_F800_0000},
    parameter int                       TMO_CYC  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_valid,
    output logic                    m_ready,
    input  logic                    m_wr,
    input  logic [XLEN/8-1:0]       m_strb,
    input  logic [XLEN-1:0]         m_addr,
    input  logic [XLEN-1:0]         m_wdata,
    output logic                    m_rvalid,
    output logic [XLEN-1:0]         m_rdata,
    output logic                    m_error,
    output logic [N_SLV-1:0]        s_cen,
    output logic                    s_wr,
    output logic [XLEN/8-1:0]       s_strb,
    output logic [XLEN-1:0]         s_addr,
    output logic [XLEN-1:0]         s_wdata,
    input  logic [N_SLV-1:0]        s_ready,
    input  logic [N_SLV*XLEN-1:0]   s_rdata,
    input  logic [N_SLV-1:0]        s_error
);

    localparam int SELW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                 r_state;
    logic [N_SLV-1:0]       r_cen;
    logic [SELW-1:0]        r_sel;
    logic                   r_wr;
    logic [XLEN/8-1:0]      r_strb;
    logic [XLEN-1:0]        r_addr;
    logic [XLEN-1:0]        r_wdata;
    logic                   r_rvalid;
    logic [XLEN-1:0]        r_rdata;
    logic                   r_error;

    logic                   w_hit;
    logic [SELW-1:0]        w_sel;
    logic                   w_rdy;
    logic                   w_err;
    logic [XLEN-1:0]        w_rdata;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
                w_hit = 1'b1;
                w_sel = SELW'(i);
            end
        end
    end

    assign w_rdy   = s_ready[r_sel];
    assign w_err   = s_error[r_sel];
    assign w_rdata = s_rdata[int'(r_sel)*XLEN +: XLEN];

`ifdef BUS_TIMEOUT_EN
    localparam int CNTW = $clog2(TMO_CYC + 1);
    logic [CNTW-1:0] r_cnt;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TMO_CYC;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cen    <= '0;
            r_sel    <= '0;
            r_wr     <= 1'b0;
            r_strb   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                    r_error  <= 1'b0;
                    if (m_valid) begin
                        r_wr    <= m_wr;
                        r_strb  <= m_strb;
                        r_addr  <= m_addr;
                        r_wdata <= m_wdata;
                        r_sel   <= w_sel;
`ifdef BUS_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                        if (w_hit) begin
                            r_cen   <= N_SLV'(1) << w_sel;
                            r_state <= ST_ACCESS;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_error  <= 1'b1;
                            r_state  <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_rdy) begin
                        r_cen    <= '0;
                        r_rvalid <= 1'b1;
                        r_error  <= w_err;
                        r_rdata  <= (r_wr || w_err) ? '0 : w_rdata;
                        r_state  <= ST_RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    // Fires on the edge where the wait count would reach TMO_CYC,
                    // so the slave sees exactly TMO_CYC select cycles.
                    else if (r_cnt == CNTW'(TMO_CYC - 1)) begin
                        r_cen    <= '0;
                        r_rvalid <= 1'b1;
                        r_error  <= 1'b1;
                        r_rdata  <= '0;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                    r_error  <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_cen   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ready  = (r_state == ST_IDLE);
    assign m_rvalid = r_rvalid;
    assign m_rdata  = r_rdata;
    assign m_error  = r_error;
    assign s_cen    = r_cen;
    assign s_wr     = r_wr;
    assign s_strb   = r_strb;
    assign s_addr   = r_addr;
    assign s_wdata  = r_wdata;

endmodule
